imem_loader: RTL

Boot-time writer for the single-cycle core's instruction memory. It accepts a framed little-endian byte stream over a valid/ready handshake, packs the bytes into 32-bit words and drives the instruction memory write port at consecutive word addresses. It holds the core in reset until a frame has loaded with a correct checksum. It sits between a byte source (UART receiver or testbench) and the instruction memory and the core's `rst_n`.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_byte_packer.sv | 48 ++++
 rtl/imem_loader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory boot loader.
//   - state_e      : loader FSM states
//   - LEN_WIDTH    : width of the frame length field (word count)
//   - is_active()  : states in which the loader consumes stream bytes
package imem_loader_pkg;

    localparam int unsigned LEN_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        DONE,
        ERROR
    } state_e;

    function automatic logic is_active(input state_e s);
        return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles little-endian bytes into 32-bit words.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_clear        : restart packing at lane 0 for a new frame
//   i_byte_en      : a byte is accepted this cycle
//   i_byte         : accepted byte
//   o_last_lane    : next accepted byte completes a word (combinational)
//   o_word_valid   : one-cycle pulse, the cycle after a word's 4th byte
//   o_word         : assembled word, stable while o_word_valid is high
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic        o_last_lane,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_lane;
    logic [31:0] r_shift;
    logic        r_word_valid;

    assign o_last_lane  = (r_lane == 2'd3);
    assign o_word_valid = r_word_valid;
    // After four shifts byte 0 sits in [7:0]; the next byte only lands at the
    // following edge, so the word is stable through the write-strobe cycle.
    assign o_word       = r_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane       <= 2'd0;
            r_shift      <= 32'd0;
            r_word_valid <= 1'b0;
        end else if (i_clear) begin
            r_lane       <= 2'd0;
            r_shift      <= 32'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= i_byte_en && o_last_lane;
            if (i_byte_en) begin
                r_lane  <= r_lane + 2'd1;
                r_shift <= {i_byte, r_shift[31:8]};
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the core's instruction memory.
// Takes a framed byte stream (LEN_LO, LEN_HI, 4*N payload bytes, checksum),
// writes payload words to consecutive addresses from 0 and releases the core
// reset only once a frame loads with a matching checksum.
//   clk, rst_n            : clock, asynchronous active-low reset
//   load_start            : arm a new load (honoured in IDLE/DONE/ERROR)
//   byte_valid/byte_data  : stream input; byte_ready accepts it
//   imem_we/waddr/wdata   : instruction-memory write port
//   cpu_rst_n             : core reset, high only in DONE
//   load_done/load_err    : frame accepted / rejected
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst_n,
    output logic                  load_done,
    output logic                  load_err
);

    localparam logic [LEN_WIDTH:0] MaxWords = (LEN_WIDTH + 1)'(1) << ADDR_WIDTH;

    state_e                r_state;
    state_e                w_state_d;
    logic                  r_byte_ready;
    logic [7:0]            r_len_lo;
    logic [LEN_WIDTH-1:0]  r_words_left;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_sum;
    logic                  r_cpu_rst_n;
    logic                  r_done;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_start;
    logic                  w_data_acc;
    logic [LEN_WIDTH-1:0]  w_len;
    logic                  w_last_lane;
    logic                  w_word_valid;
    logic [31:0]           w_word;

    assign w_accept   = byte_valid && r_byte_ready;
    assign w_start    = load_start && ((r_state == IDLE) || (r_state == DONE) ||
                                       (r_state == ERROR));
    assign w_data_acc = w_accept && (r_state == S_DATA);
    assign w_len      = {byte_data, r_len_lo};

    byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_start),
        .i_byte_en    (w_data_acc),
        .i_byte       (byte_data),
        .o_last_lane  (w_last_lane),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE, DONE, ERROR: begin
                if (load_start) w_state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept) w_state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    if ({1'b0, w_len} > MaxWords) begin
                        w_state_d = ERROR;
                    end else if (w_len == '0) begin
                        w_state_d = S_CHECK;
                    end else begin
                        w_state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && w_last_lane && (r_words_left == LEN_WIDTH'(1))) begin
                    w_state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_accept) w_state_d = (byte_data == r_sum) ? DONE : ERROR;
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_ready <= 1'b0;
            r_cpu_rst_n  <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_byte_ready <= is_active(w_state_d);
            r_cpu_rst_n  <= (w_state_d == DONE);
            r_done       <= (w_state_d == DONE);
            r_err        <= (w_state_d == ERROR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_lo     <= 8'd0;
            r_words_left <= '0;
            r_waddr      <= '0;
            r_sum        <= 8'd0;
        end else if (w_start) begin
            r_words_left <= '0;
            r_waddr      <= '0;
            r_sum        <= 8'd0;
        end else begin
            if (w_accept && (r_state == S_LEN_LO)) r_len_lo <= byte_data;
            if (w_accept && (r_state == S_LEN_HI)) r_words_left <= w_len;
            if (w_data_acc) begin
                r_sum <= r_sum + byte_data;
                if (w_last_lane) r_words_left <= r_words_left - LEN_WIDTH'(1);
            end
            // Address advances after the strobe cycle so the write sees the old value.
            if (w_word_valid) r_waddr <= r_waddr + ADDR_WIDTH'(1);
        end
    end

    assign byte_ready = r_byte_ready;
    assign imem_we    = w_word_valid;
    assign imem_waddr = r_waddr;
    assign imem_wdata = w_word;
    assign cpu_rst_n  = r_cpu_rst_n;
    assign load_done  = r_done;
    assign load_err   = r_err;

endmodule
